multicycle_control_fsm: RTL and testbench

Sequencing controller for the multicycle RV32I datapath, which has one shared instruction/data memory, IR/OldPC/A/ALUOut/Data registers and a single ALU. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives all datapath enables and muxes, and stalls on a memory ready handshake. It supports the same subset as the single-cycle core: add/sub/sll/xor/and, addi, lw, sw, beq, bne, jal and jalr.

---
 rtl/multicycle_control_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle RV32I datapath.
// One state register and a sticky illegal flag; all datapath controls decode combinationally from state.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    JAL      = STATE_W'(10),
    JALR     = STATE_W'(11),
    JALRLINK = STATE_W'(12),
    TRAP     = STATE_W'(13)
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_ITYPE  = 7'd19;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b111;

  state_t r_state;
  state_t w_next;
  state_t w_decode_next;
  logic   r_illegal;
  logic   w_is_store;

  assign w_is_store = (op == OP_STORE);

  always_comb begin
    w_decode_next = TRAP;
    case (op)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) w_decode_next = MEMADR;
      OP_RTYPE: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b111)
          w_decode_next = EXECR;
      end
      OP_ITYPE:  if (funct3 == 3'b000) w_decode_next = EXECI;
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) w_decode_next = BRANCH;
      OP_JAL:    w_decode_next = JAL;
      OP_JALR:   w_decode_next = JALR;
      default:   w_decode_next = TRAP;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (mem_ready) w_next = DECODE;
      DECODE:   w_next = w_decode_next;
      MEMADR:   w_next = w_is_store ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (mem_ready) w_next = FETCH;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      JAL:      w_next = ALUWB;
      JALR:     w_next = JALRLINK;
      JALRLINK: w_next = FETCH;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    RegWrite   = 1'b0;
    case (r_state)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        // Branch/jal target is precomputed here into ALUOut from OldPC + imm.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 2'b11 : 2'b10;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = w_is_store ? 2'b01 : 2'b00;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        case (funct3)
          3'b000:  ALUControl = funct7 ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b100:  ALUControl = ALU_XOR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      JALRLINK: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
    // A reset abandons the instruction: no PC, IR, memory or register write may fire.
    if (rst) begin
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign illegal   = r_illegal;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class state by state
// and compares state and the full control word against hand-written expectations.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [16:0] w_ctl;
  assign w_ctl = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite};

  function automatic logic [16:0] ctl(input logic pcw, input logic adr, input logic mr,
                                      input logic mw, input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic rw);
    return {pcw, adr, mr, mw, irw, rs, sa, sb, alu, imm, rw};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle the current inputs, compare state/control/illegal, then advance one clock.
  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c,
                      input logic ill);
    #1;
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".ctl"}, 32'(w_ctl), 32'(c));
    check({tag, ".illegal"}, 32'(illegal), 32'(ill));
    tick();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    // Reset held in FETCH with mem_ready=1: enables must stay low.
    step("rst_hold", 4'd0, ctl(0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);

    // addi x1,x0,5 (0x00500093)
    rst = 1'b0; set_instr(7'd19, 3'd0, 1'b0);
    step("addi.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("addi.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("addi.execi",  4'd7, ctl(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,2'd0,0), 1'b0);
    step("addi.aluwb",  4'd8, ctl(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,1), 1'b0);

    // lw with two stall cycles in MEMREAD
    set_instr(7'd3, 3'd2, 1'b0);
    step("lw.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("lw.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("lw.memadr", 4'd2, ctl(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,2'd0,0), 1'b0);
    mem_ready = 1'b0;
    step("lw.memrd0", 4'd3, ctl(0,1,1,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
    step("lw.memrd1", 4'd3, ctl(0,1,1,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
    mem_ready = 1'b1;
    step("lw.memrd2", 4'd3, ctl(0,1,1,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
    step("lw.memwb",  4'd4, ctl(0,0,0,0,0,2'd1,2'd0,2'd0,3'd0,2'd0,1), 1'b0);

    // beq taken, bne not taken (Zero=1), bne taken (Zero=0)
    set_instr(7'd99, 3'd0, 1'b0); Zero = 1'b1;
    step("beq.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("beq.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("beq.branch", 4'd9, ctl(1,0,0,0,0,2'd0,2'd2,2'd0,3'd2,2'd0,0), 1'b0);
    set_instr(7'd99, 3'd1, 1'b0);
    step("bne.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("bne.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("bne.branch", 4'd9, ctl(0,0,0,0,0,2'd0,2'd2,2'd0,3'd2,2'd0,0), 1'b0);
    Zero = 1'b0;
    step("bne2.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("bne2.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("bne2.branch", 4'd9, ctl(1,0,0,0,0,2'd0,2'd2,2'd0,3'd2,2'd0,0), 1'b0);

    // jalr
    set_instr(7'd103, 3'd0, 1'b0);
    step("jalr.fetch",  4'd0,  ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("jalr.decode", 4'd1,  ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("jalr.jalr",   4'd11, ctl(1,0,0,0,0,2'd2,2'd2,2'd1,3'd0,2'd0,0), 1'b0);
    step("jalr.link",   4'd12, ctl(0,0,0,0,0,2'd2,2'd1,2'd2,3'd0,2'd0,1), 1'b0);

    // jal
    set_instr(7'd111, 3'd0, 1'b0);
    step("jal.fetch",  4'd0,  ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("jal.decode", 4'd1,  ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd3,0), 1'b0);
    step("jal.jal",    4'd10, ctl(1,0,0,0,0,2'd0,2'd1,2'd2,3'd0,2'd0,0), 1'b0);
    step("jal.aluwb",  4'd8,  ctl(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,1), 1'b0);

    // sub, sll, xor, and through EXECR
    set_instr(7'd51, 3'd0, 1'b1);
    step("sub.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("sub.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("sub.execr",  4'd6, ctl(0,0,0,0,0,2'd0,2'd2,2'd0,3'd2,2'd0,0), 1'b0);
    step("sub.aluwb",  4'd8, ctl(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,1), 1'b0);
    set_instr(7'd51, 3'd1, 1'b0);
    tick(); tick();
    step("sll.execr",  4'd6, ctl(0,0,0,0,0,2'd0,2'd2,2'd0,3'd1,2'd0,0), 1'b0);
    tick();
    set_instr(7'd51, 3'd4, 1'b0);
    tick(); tick();
    step("xor.execr",  4'd6, ctl(0,0,0,0,0,2'd0,2'd2,2'd0,3'd4,2'd0,0), 1'b0);
    tick();
    set_instr(7'd51, 3'd7, 1'b0);
    tick(); tick();
    step("and.execr",  4'd6, ctl(0,0,0,0,0,2'd0,2'd2,2'd0,3'd7,2'd0,0), 1'b0);
    tick();

    // sw with a FETCH stall and a MEMWRITE stall, exactly one accepted write
    set_instr(7'd35, 3'd2, 1'b0); mem_ready = 1'b0;
    step("sw.fetchst", 4'd0, ctl(0,0,1,0,0,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    mem_ready = 1'b1;
    step("sw.fetch",   4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("sw.decode",  4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    step("sw.memadr",  4'd2, ctl(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,2'd1,0), 1'b0);
    mem_ready = 1'b0;
    step("sw.memwr0",  4'd5, ctl(0,1,0,1,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
    mem_ready = 1'b1;
    step("sw.memwr1",  4'd5, ctl(0,1,0,1,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
    #1 check("sw.done", 32'(state_dbg), 32'd0);

    // sw abandoned by reset while stalled in MEMWRITE
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1 check("swrst.pre", 32'(state_dbg), 32'd5);
    rst = 1'b1;
    step("swrst.rst", 4'd5, ctl(0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b0);
    rst = 1'b0;
    step("swrst.post", 4'd0, ctl(0,0,1,0,0,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);

    // Unsupported R-type funct3 traps; sticky until reset
    mem_ready = 1'b1; set_instr(7'd51, 3'd2, 1'b0);
    step("trap.fetch",  4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);
    step("trap.decode", 4'd1, ctl(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,2'd2,0), 1'b0);
    set_instr(7'd19, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("trap.hold", 4'd13, ctl(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0), 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    step("trap.clear", 4'd0, ctl(1,0,1,0,1,2'd2,2'd0,2'd2,3'd0,2'd0,0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
